hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 52 +++++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The master side is the pipeline datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             regWrite_M;
  logic             regWrite_W;
  logic [4:0]       rd_M;
  logic [4:0]       rd_W;
  logic [4:0]       rd_E;
  logic [4:0]       rs1_D;
  logic [4:0]       rs2_D;
  logic [4:0]       rs1_E;
  logic [4:0]       rs2_E;
  logic             use_rs1_D;
  logic             use_rs2_D;
  logic [2:0]       resultSrc_E;
  logic             PCSrc_E;
  logic             md_start_E;
  logic             md_done;
  logic             dmem_req_M;
  logic             dmem_ready_M;

  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             stall_M;
  logic             flush_D;
  logic             flush_E;
  logic             flush_M;
  logic             flush_W;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output regWrite_M, regWrite_W, rd_M, rd_W, rd_E, rs1_D, rs2_D, rs1_E, rs2_E,
           use_rs1_D, use_rs2_D, resultSrc_E, PCSrc_E, md_start_E, md_done,
           dmem_req_M, dmem_ready_M,
    input  forwardAE, forwardBE, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M, flush_W, stall_cnt, flush_cnt
  );

  modport slave (
    input  regWrite_M, regWrite_W, rd_M, rd_W, rd_E, rs1_D, rs2_D, rs1_E, rs2_E,
           use_rs1_D, use_rs2_D, resultSrc_E, PCSrc_E, md_start_E, md_done,
           dmem_req_M, dmem_ready_M,
    output forwardAE, forwardBE, stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_M, flush_W, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use / mul-div / memory-wait
// stalls, branch flushes, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter logic [2:0]  LOAD_SRC     = 3'b001,
  parameter int unsigned CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, MDW} state_t;

  state_t             state_q, state_d;
  logic [1:0]         bub_q, bub_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic memw, lu;
  logic stall_f, stall_dd, stall_e, stall_m;
  logic flush_dd, flush_e, flush_m, flush_w;

  function automatic logic [1:0] fwd_sel(input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw,
                                         input logic [4:0] rs);
    if (wm && (rdm != '0) && (rdm == rs))      return 2'b10;
    else if (ww && (rdw != '0) && (rdw == rs)) return 2'b01;
    else                                       return 2'b00;
  endfunction

  assign bus.forwardAE = fwd_sel(bus.regWrite_M, bus.rd_M, bus.regWrite_W, bus.rd_W, bus.rs1_E);
  assign bus.forwardBE = fwd_sel(bus.regWrite_M, bus.rd_M, bus.regWrite_W, bus.rd_W, bus.rs2_E);

  assign memw = bus.dmem_req_M && !bus.dmem_ready_M;
  assign lu   = (bus.resultSrc_E == LOAD_SRC) && (bus.rd_E != '0) &&
                ((bus.use_rs1_D && (bus.rs1_D == bus.rd_E)) ||
                 (bus.use_rs2_D && (bus.rs2_D == bus.rd_E)));

  // Memory wait freezes everything, including the FSM; the branch in E only
  // redirects on cycles where E is allowed to advance.
  always_comb begin
    state_d  = state_q;
    bub_d    = bub_q;
    stall_f  = 1'b0;
    stall_dd = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_dd = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_w  = 1'b0;
    if (memw) begin
      stall_f  = 1'b1;
      stall_dd = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      flush_w  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.md_start_E && !lu) begin
            stall_f  = 1'b1;
            stall_dd = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
            state_d  = MDW;
          end else if (bus.PCSrc_E) begin
            flush_dd = 1'b1;
            flush_e  = 1'b1;
          end else if (lu) begin
            stall_f  = 1'b1;
            stall_dd = 1'b1;
            flush_e  = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = LOAD;
              bub_d   = 2'(LOAD_BUBBLES - 1);
            end
          end
        end
        LOAD: begin
          if (bus.PCSrc_E) begin
            flush_dd = 1'b1;
            flush_e  = 1'b1;
            state_d  = IDLE;
            bub_d    = '0;
          end else begin
            stall_f  = 1'b1;
            stall_dd = 1'b1;
            flush_e  = 1'b1;
            bub_d    = bub_q - 2'd1;
            if (bub_q == 2'd1) state_d = IDLE;
          end
        end
        MDW: begin
          if (bus.md_done) begin
            state_d = IDLE;
            if (bus.PCSrc_E) begin
              flush_dd = 1'b1;
              flush_e  = 1'b1;
            end
          end else begin
            stall_f  = 1'b1;
            stall_dd = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          bub_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((flush_dd || flush_e || flush_m || flush_w) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bub_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_F   = stall_f;
  assign bus.stall_D   = stall_dd;
  assign bus.stall_E   = stall_e;
  assign bus.stall_M   = stall_m;
  assign bus.flush_D   = flush_dd;
  assign bus.flush_E   = flush_e;
  assign bus.flush_M   = flush_m;
  assign bus.flush_W   = flush_w;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule
